// File: rtl/esc_cmd_ramp.sv
// esc_cmd_ramp: throttle conditioner ahead of the esc PWM generator.
// Latches 10-bit requests, gates output behind an arming sequence and slew-limits cmd.
// Ports: clk_1M, rst_n (async, active-low), req[9:0], req_valid, arm_req
//        -> cmd[9:0], armed, failsafe (all registered).
// Macro ESC_CMD_RAMP_FAILSAFE_EN adds the request timeout and FAILSAFE ramp-down.
`timescale 1ns/1ps
module esc_cmd_ramp #(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned ARM_TICKS     = 2000,
  parameter int unsigned TIMEOUT_TICKS = 100
) (
  input  logic       clk_1M,
  input  logic       rst_n,
  input  logic [9:0] req,
  input  logic       req_valid,
  input  logic       arm_req,
  output logic [9:0] cmd,
  output logic       armed,
  output logic       failsafe
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = $clog2(ARM_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TICKS);
  localparam logic [10:0]   STEP     = 11'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_DIS,
    ST_ARMING,
    ST_ARMED,
    ST_FS
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [AW-1:0]   arm_q, arm_d, arm_inc;
  logic [9:0]      tgt_q, tgt_d;
  logic [9:0]      cmd_q, cmd_d;
  logic            armed_q, armed_d;
  logic            tick;
  logic            to_hit;
  logic [10:0]     goal, cur, up, dn;
  logic [9:0]      ramp;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign tgt_d = req_valid ? req : tgt_q;

  assign arm_inc = arm_q + 1'b1;

  // Counter only runs while arming; any other state leaves it cleared.
  always_comb begin
    arm_d = arm_q;
    if (state_q != ST_ARMING) begin
      arm_d = '0;
    end else if (tick) begin
      arm_d = arm_inc;
    end
  end

  // 11-bit arithmetic keeps the step from wrapping past 0 or 1023.
  always_comb begin
    goal = (state_q == ST_FS) ? 11'd0 : {1'b0, tgt_q};
    cur  = {1'b0, cmd_q};
    up   = cur + STEP;
    dn   = cur - STEP;
    ramp = cmd_q;
    if (goal >= cur) begin
      if (goal - cur <= STEP) ramp = goal[9:0];
      else                    ramp = up[9:0];
    end else begin
      if (cur - goal <= STEP) ramp = goal[9:0];
      else                    ramp = dn[9:0];
    end
  end

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DIS;
      div_q   <= '0;
      arm_q   <= '0;
      tgt_q   <= '0;
      cmd_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      arm_q   <= arm_d;
      tgt_q   <= tgt_d;
      cmd_q   <= cmd_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DIS: begin
        if (arm_req && tgt_q == '0) state_d = ST_ARMING;
      end
      ST_ARMING: begin
        if (!arm_req || tgt_q != '0)         state_d = ST_DIS;
        else if (tick && arm_inc == ARM_LAST) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm_req)    state_d = ST_DIS;
        else if (to_hit) state_d = ST_FS;
      end
      ST_FS: begin
        if (!arm_req)                  state_d = ST_DIS;
        else if (tick && ramp == '0) state_d = ST_DIS;
      end
      default: state_d = ST_DIS;
    endcase
  end

  // Ramp follows the state being left; leaving to DIS/ARMING zeroes cmd.
  always_comb begin
    cmd_d   = cmd_q;
    armed_d = (state_d == ST_ARMED) || (state_d == ST_FS);
    if (state_d == ST_DIS || state_d == ST_ARMING) begin
      cmd_d = '0;
    end else if (tick &&
                 (state_q == ST_ARMED || state_q == ST_FS)) begin
      cmd_d = ramp;
    end
  end

  assign cmd   = cmd_q;
  assign armed = armed_q;

`ifdef ESC_CMD_RAMP_FAILSAFE_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] to_q, to_d;
  logic          fs_q;

  // A strobe always wins over a same-cycle tick.
  always_comb begin
    to_d = to_q;
    if (req_valid)                    to_d = '0;
    else if (tick && to_q != TO_MAX)  to_d = to_q + 1'b1;
  end

  assign to_hit = (to_q == TO_MAX);

  always_ff @(posedge clk_1M or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
      fs_q <= 1'b0;
    end else begin
      to_q <= to_d;
      fs_q <= (state_d == ST_FS);
    end
  end

  assign failsafe = fs_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_TICKS == 0);
  assign to_hit     = 1'b0;
  assign failsafe   = 1'b0;
`endif

endmodule
